// File: rtl/cpu_commit_skid_reg.sv
// ---------------------------------------------------------------------------
// cpu_commit_skid_reg
//
// EX->MEM commit pipeline register with a two-entry skid buffer. The execute
// stage hands over one commit bundle per accepted handshake; the memory stage
// sees the oldest held bundle (the head) and pops it with out_ready. A second
// (skid) entry absorbs the bundle that was already in flight when the memory
// stage stalled, so in_ready can be a registered function of occupancy with no
// combinational path from out_ready.
//
// Parameters
//   REG_WIDTH  width of alu_result / rb_data
//   NUM_REGS   register file size (power of two, >= 2); sets reg_dest width
//   CNT_WIDTH  width of the stall performance counter
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               drop every held bundle; input of that cycle is ignored
//   in_valid / in_ready execute-side handshake
//   in_*                commit bundle from execute (8 fields)
//   out_valid/out_ready memory-side handshake
//   out_*               head bundle toward memory (8 fields); memory side-effect
//                       strobes are forced low while out_valid is low
//   stall_cnt           saturating count of cycles with out_valid & !out_ready
//   stall_clr           synchronous clear of stall_cnt (wins over increment)
// ---------------------------------------------------------------------------
module cpu_commit_skid_reg #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,

    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mem_write,
    input  logic                        in_mem_read,
    input  logic                        in_mem_to_reg,
    input  logic                        in_reg_write,
    input  logic [REG_WIDTH-1:0]        in_alu_result,
    input  logic [REG_WIDTH-1:0]        in_rb_data,
    input  logic [$clog2(NUM_REGS)-1:0] in_reg_dest,
    input  logic                        in_zero,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_mem_write,
    output logic                        out_mem_read,
    output logic                        out_mem_to_reg,
    output logic                        out_reg_write,
    output logic [REG_WIDTH-1:0]        out_alu_result,
    output logic [REG_WIDTH-1:0]        out_rb_data,
    output logic [$clog2(NUM_REGS)-1:0] out_reg_dest,
    output logic                        out_zero,

    output logic [CNT_WIDTH-1:0]        stall_cnt,
    input  logic                        stall_clr
);

    localparam int DEST_W = $clog2(NUM_REGS);
    // Packed bundle: {mem_write, mem_read, mem_to_reg, reg_write,
    //                 alu_result, rb_data, reg_dest, zero}
    localparam int BW     = 4 + 2 * REG_WIDTH + DEST_W + 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t          state_p0;
    state_t          state_nxt;

    logic [BW-1:0]   in_bundle;
    logic [BW-1:0]   head_p0;
    logic [BW-1:0]   skid_p0;

    logic            accept;
    logic            drain;
    logic            load_head_in;
    logic            load_head_skid;
    logic            load_skid_in;
    logic            vld_p0;

    logic            hd_mem_write;
    logic            hd_mem_read;
    logic            hd_reg_write;

    // Saturating increment for the performance counter.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        logic [CNT_WIDTH-1:0] one;
        one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        if (c == {CNT_WIDTH{1'b1}}) begin
            return c;
        end
        return c + one;
    endfunction

    assign in_bundle = {in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write,
                        in_alu_result, in_rb_data, in_reg_dest, in_zero};

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // ---- stage p0: occupancy state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= S_EMPTY;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // Next state and entry-load strobes. Flush overrides everything: nothing
    // is captured, and a drain in the same cycle has already completed at the
    // memory side, so simply emptying is correct.
    always_comb begin
        state_nxt      = state_p0;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            unique case (state_p0)
                S_EMPTY: begin
                    if (accept) begin
                        state_nxt    = S_ONE;
                        load_head_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        state_nxt    = S_TWO;
                        load_skid_in = 1'b1;
                    end else if (drain) begin
                        state_nxt    = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        state_nxt      = S_ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs depend on the registered state only, keeping
    // out_ready -> in_ready and in_* -> out_* free of combinational paths.
    always_comb begin
        vld_p0   = (state_p0 != S_EMPTY);
        in_ready = (state_p0 != S_TWO);
    end

    assign out_valid = vld_p0;

    // ---- stage p0: head and skid entries ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_p0 <= '0;
            skid_p0 <= '0;
        end else begin
            if (load_head_in) begin
                head_p0 <= in_bundle;
            end else if (load_head_skid) begin
                head_p0 <= skid_p0;
            end
            if (load_skid_in) begin
                skid_p0 <= in_bundle;
            end
        end
    end

    assign {hd_mem_write, hd_mem_read, out_mem_to_reg, hd_reg_write,
            out_alu_result, out_rb_data, out_reg_dest, out_zero} = head_p0;

    // Stale head data must never trigger a memory access or a writeback.
    assign out_mem_write = hd_mem_write & vld_p0;
    assign out_mem_read  = hd_mem_read  & vld_p0;
    assign out_reg_write = hd_reg_write & vld_p0;

    // ---- stage p0: stall performance counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_cpu_commit_skid_reg.sv
module tb_cpu_commit_skid_reg;

    localparam int RW = 32;
    localparam int NR = 32;
    localparam int CW = 16;
    localparam int DW = $clog2(NR);

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_mem_write;
    logic          in_mem_read;
    logic          in_mem_to_reg;
    logic          in_reg_write;
    logic [RW-1:0] in_alu_result;
    logic [RW-1:0] in_rb_data;
    logic [DW-1:0] in_reg_dest;
    logic          in_zero;
    logic          out_valid;
    logic          out_ready;
    logic          out_mem_write;
    logic          out_mem_read;
    logic          out_mem_to_reg;
    logic          out_reg_write;
    logic [RW-1:0] out_alu_result;
    logic [RW-1:0] out_rb_data;
    logic [DW-1:0] out_reg_dest;
    logic          out_zero;
    logic [CW-1:0] stall_cnt;
    logic          stall_clr;

    cpu_commit_skid_reg #(.REG_WIDTH(RW), .NUM_REGS(NR), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_alu_result(in_alu_result), .in_rb_data(in_rb_data),
        .in_reg_dest(in_reg_dest), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
        .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
        .out_alu_result(out_alu_result), .out_rb_data(out_rb_data),
        .out_reg_dest(out_reg_dest), .out_zero(out_zero),
        .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          mw;
        logic          mr;
        logic          m2r;
        logic          rw;
        logic [RW-1:0] alu;
        logic [RW-1:0] rb;
        logic [DW-1:0] rd;
        logic          z;
    } bundle_t;

    typedef struct {
        logic          iv;
        logic          ordy;
        logic [RW-1:0] alu;
        logic          e_ov;
        logic          e_ir;
        logic [RW-1:0] e_alu;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input bundle_t b, input logic v);
        in_valid      = v;
        in_mem_write  = b.mw;
        in_mem_read   = b.mr;
        in_mem_to_reg = b.m2r;
        in_reg_write  = b.rw;
        in_alu_result = b.alu;
        in_rb_data    = b.rb;
        in_reg_dest   = b.rd;
        in_zero       = b.z;
    endtask

    function automatic bundle_t mk(input logic [RW-1:0] alu, input logic mw, input logic rw);
        bundle_t b;
        b.mw  = mw;
        b.mr  = 1'b0;
        b.m2r = 1'b0;
        b.rw  = rw;
        b.alu = alu;
        b.rb  = alu ^ 32'hFFFF_0000;
        b.rd  = alu[DW-1:0];
        b.z   = (alu == '0);
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t    tbl[10];
    bundle_t q[$];
    bundle_t rb_b;
    bundle_t hd;
    int      m_cnt;
    logic    m_acc;
    logic    m_drn;

    initial begin
        // stream: 1,2,3,4 back-to-back with memory always ready
        tbl[0] = '{1'b1, 1'b1, 32'h1, 1'b1, 1'b1, 32'h1};
        tbl[1] = '{1'b1, 1'b1, 32'h2, 1'b1, 1'b1, 32'h2};
        tbl[2] = '{1'b1, 1'b1, 32'h3, 1'b1, 1'b1, 32'h3};
        tbl[3] = '{1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 32'h4};
        tbl[4] = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0};
        // back-pressure: A, B fill both entries; C is refused; then drain A, B
        tbl[5] = '{1'b1, 1'b0, 32'hA, 1'b1, 1'b1, 32'hA};
        tbl[6] = '{1'b1, 1'b0, 32'hB, 1'b1, 1'b0, 32'hA};
        tbl[7] = '{1'b1, 1'b0, 32'hC, 1'b1, 1'b0, 32'hA};
        tbl[8] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'hB};
        tbl[9] = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0};

        rst_n = 1'b1; flush = 1'b0; stall_clr = 1'b0; out_ready = 1'b0;
        apply(mk(32'h0, 1'b0, 1'b0), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_alu", 64'(out_alu_result), 64'd0);
        check("rst_out_mem_write", 64'(out_mem_write), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // table-driven stream and back-pressure
        for (int i = 0; i < 10; i++) begin
            apply(mk(tbl[i].alu, 1'b0, 1'b1), tbl[i].iv);
            out_ready = tbl[i].ordy;
            step();
            check($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            check($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
            if (tbl[i].e_ov)
                check($sformatf("tbl%0d_out_alu", i), 64'(out_alu_result), 64'(tbl[i].e_alu));
        end

        // flush while full, input presented with a store
        out_ready = 1'b0;
        apply(mk(32'h11, 1'b0, 1'b0), 1'b1); step();
        apply(mk(32'h22, 1'b0, 1'b0), 1'b1); step();
        check("fl_two_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        apply(mk(32'hDEAD, 1'b1, 1'b1), 1'b1); step();
        flush = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_out_mem_write", 64'(out_mem_write), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        apply(mk(32'h0, 1'b0, 1'b0), 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_no_ghost", 64'(out_valid), 64'd0);
        end
        // flush with a handshake that would otherwise be accepted
        apply(mk(32'h33, 1'b0, 1'b0), 1'b1); out_ready = 1'b0; step();
        flush = 1'b1;
        apply(mk(32'h44, 1'b1, 1'b0), 1'b1); step();
        flush = 1'b0;
        apply(mk(32'h0, 1'b0, 1'b0), 1'b0);
        check("fl1_out_valid", 64'(out_valid), 64'd0);
        step();
        check("fl1_no_capture", 64'(out_valid), 64'd0);

        // stall counter saturation and clear
        stall_clr = 1'b1; step(); stall_clr = 1'b0;
        check("cnt_clr0", 64'(stall_cnt), 64'd0);
        out_ready = 1'b0;
        apply(mk(32'h55, 1'b0, 1'b0), 1'b1); step();
        apply(mk(32'h0, 1'b0, 1'b0), 1'b0);
        for (int i = 0; i < 65600; i++) @(posedge clk);
        #1;
        check("cnt_saturated", 64'(stall_cnt), 64'hFFFF);
        stall_clr = 1'b1; step(); stall_clr = 1'b0;
        check("cnt_clr_wins", 64'(stall_cnt), 64'd0);
        step();
        check("cnt_restart", 64'(stall_cnt), 64'd1);
        out_ready = 1'b1; step();
        check("cnt_drain_valid", 64'(out_valid), 64'd0);
        check("cnt_hold", 64'(stall_cnt), 64'd1);

        // asynchronous reset while holding two bundles
        out_ready = 1'b0;
        apply(mk(32'hA1, 1'b1, 1'b1), 1'b1); step();
        apply(mk(32'hA2, 1'b1, 1'b1), 1'b1); step();
        apply(mk(32'h0, 1'b0, 1'b0), 1'b0);
        check("ar_pre_in_ready", 64'(in_ready), 64'd0);
        check("ar_pre_mem_write", 64'(out_mem_write), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        check("ar_out_alu", 64'(out_alu_result), 64'd0);
        check("ar_out_rb", 64'(out_rb_data), 64'd0);
        check("ar_out_mem_write", 64'(out_mem_write), 64'd0);
        check("ar_out_reg_write", 64'(out_reg_write), 64'd0);
        check("ar_stall_cnt", 64'(stall_cnt), 64'd0);
        #2 rst_n = 1'b1;
        step();
        check("ar_post_valid", 64'(out_valid), 64'd0);
        apply(mk(32'hB1, 1'b0, 1'b1), 1'b1); out_ready = 1'b1; step();
        check("ar_resume_valid", 64'(out_valid), 64'd1);
        check("ar_resume_alu", 64'(out_alu_result), 64'hB1);
        apply(mk(32'h0, 1'b0, 1'b0), 1'b0); step();
        check("ar_resume_drain", 64'(out_valid), 64'd0);

        // randomized traffic against a queue model
        flush = 1'b1; stall_clr = 1'b1; step();
        flush = 1'b0; stall_clr = 1'b0;
        q.delete();
        m_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            check("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
            check("rnd_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
            if (q.size() > 0) begin
                hd = q[0];
                check("rnd_alu_rb", {out_alu_result, out_rb_data}, {hd.alu, hd.rb});
                check("rnd_ctl", 64'({out_mem_write, out_mem_read, out_mem_to_reg,
                                      out_reg_write, out_reg_dest, out_zero}),
                      64'({hd.mw, hd.mr, hd.m2r, hd.rw, hd.rd, hd.z}));
            end else begin
                check("rnd_gated", 64'({out_mem_write, out_mem_read, out_reg_write}), 64'd0);
            end
            rb_b     = bundle_t'({$urandom, $urandom, $urandom});
            apply(rb_b, ($urandom_range(0, 9) < 6));
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 31) == 0);
            stall_clr = ($urandom_range(0, 63) == 0);
            m_acc = in_valid && (q.size() < 2);
            m_drn = out_ready && (q.size() > 0);
            if (stall_clr) m_cnt = 0;
            else if (q.size() > 0 && !out_ready && m_cnt < 65535) m_cnt++;
            step();
            if (flush) begin
                q.delete();
            end else begin
                if (m_drn) void'(q.pop_front());
                if (m_acc) q.push_back(rb_b);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
